// File: rtl/z80_arb_pkg.sv
// Shared definitions for the Z80 / video SRAM arbiter.
// Holds the access-state encoding, the default SRAM access length and the
// value the CPU read-data latch comes out of reset with.
package z80_arb_pkg;

  // Arbiter states: one idle state plus one state per kind of SRAM access.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VID    = 2'd1,
    CPU_RD = 2'd2,
    CPU_WR = 2'd3
  } arb_state_t;

  // Clocks per SRAM access when the top-level parameter is left alone.
  localparam int SRAM_CYCLES_DEF = 2;

  // Idle-bus value seen by the CPU before its first read completes.
  localparam logic [7:0] CPU_DIN_RST = 8'hFF;

endpackage

// File: rtl/z80_sram_arbiter_if.sv
// Bundle of every signal the arbiter exchanges with the CPU wrapper, the
// video fetcher and the SRAM pins.
//   CPU side   : mreq_n, rd_n, wr_n, A, cpu_dout (to arbiter); cpu_din, wait_n
//   Video side : vreq, vaddr (to arbiter); vack, vdata
//   SRAM side  : sram_dq_in (to arbiter); sram_addr, sram_oe_n, sram_we_n,
//                sram_dq_out, sram_dq_oe
// The arbiter uses the slave modport; whatever surrounds it uses master.
interface z80_sram_arbiter_if #(
  parameter int ADDR_W = 16
);

  logic              mreq_n;
  logic              rd_n;
  logic              wr_n;
  logic [15:0]       A;
  logic [7:0]        cpu_dout;
  logic [7:0]        cpu_din;
  logic              wait_n;

  logic              vreq;
  logic [ADDR_W-1:0] vaddr;
  logic              vack;
  logic [7:0]        vdata;

  logic [ADDR_W-1:0] sram_addr;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [7:0]        sram_dq_out;
  logic              sram_dq_oe;
  logic [7:0]        sram_dq_in;

  modport slave (
    input  mreq_n, rd_n, wr_n, A, cpu_dout, vreq, vaddr, sram_dq_in,
    output cpu_din, wait_n, vack, vdata,
           sram_addr, sram_oe_n, sram_we_n, sram_dq_out, sram_dq_oe
  );

  modport master (
    output mreq_n, rd_n, wr_n, A, cpu_dout, vreq, vaddr, sram_dq_in,
    input  cpu_din, wait_n, vack, vdata,
           sram_addr, sram_oe_n, sram_we_n, sram_dq_out, sram_dq_oe
  );

endinterface

// File: rtl/z80_cpu_req_tracker.sv
// Tracks whether the current Z80 bus cycle has already had its SRAM access.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   mreq_n     : CPU memory request (active low)
//   rd_n, wr_n : CPU read/write strobes (active low)
//   cpu_done   : pulse from the arbiter on the clock a CPU access finishes
//   cpu_req    : a CPU access is wanted and not yet served this bus cycle
//   wait_n     : CPU wait line, low while cpu_req is pending
module z80_cpu_req_tracker (
  input  logic clk,
  input  logic rst,
  input  logic mreq_n,
  input  logic rd_n,
  input  logic wr_n,
  input  logic cpu_done,
  output logic cpu_req,
  output logic wait_n
);

  logic served;

  // Completion takes precedence over the clear so an access that finishes
  // after the CPU already let go of mreq_n still drops served one clock later.
  always_ff @(posedge clk) begin
    if (rst) begin
      served <= 1'b0;
    end else if (cpu_done) begin
      served <= 1'b1;
    end else if (mreq_n) begin
      served <= 1'b0;
    end
  end

  // Combinational so the CPU is held in the very cycle it asks.
  assign cpu_req = !mreq_n && (!rd_n || !wr_n) && !served;
  assign wait_n  = !cpu_req;

endmodule

// File: rtl/z80_sram_arbiter.sv
// Shares one asynchronous SRAM between the Z80 bus and a video fetcher.
// Every access is a fixed SRAM_CYCLES-clock cycle followed by at least one
// idle clock for bus turnaround. Video has fixed priority by default, so a
// continuously requesting fetcher starves the CPU (it sits in wait).
// Optional feature macro: ARB_ROUNDROBIN_EN -- when defined, contested
// grants alternate between video and CPU based on the last grant type.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : z80_sram_arbiter_if slave modport (CPU, video and SRAM pins)
// Parameters:
//   SRAM_CYCLES : clocks per access (>= 1), OE_n/WE_n low for exactly this long
//   ADDR_W      : SRAM address width, CPU address zero-extended to it
module z80_sram_arbiter
  import z80_arb_pkg::*;
#(
  parameter int SRAM_CYCLES = SRAM_CYCLES_DEF,
  parameter int ADDR_W      = 16
) (
  input logic              clk,
  input logic              rst,
  z80_sram_arbiter_if.slave bus
);

  localparam int CNT_W = (SRAM_CYCLES > 1) ? $clog2(SRAM_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_CYCLES - 1);

  arb_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              oe_n_q;
  logic              we_n_q;
  logic              dq_oe_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        dq_out_q;
  logic [7:0]        cpu_din_q;
  logic [7:0]        vdata_q;
  logic              vack_q;

  logic cpu_req;
  logic cpu_wait_n;
  logic last_cnt;
  logic cpu_done;
  logic grant_vid;

  assign last_cnt = (cnt == CNT_LAST);
  assign cpu_done = ((state == CPU_RD) || (state == CPU_WR)) && last_cnt;

  z80_cpu_req_tracker u_req_tracker (
    .clk      (clk),
    .rst      (rst),
    .mreq_n   (bus.mreq_n),
    .rd_n     (bus.rd_n),
    .wr_n     (bus.wr_n),
    .cpu_done (cpu_done),
    .cpu_req  (cpu_req),
    .wait_n   (cpu_wait_n)
  );

`ifdef ARB_ROUNDROBIN_EN
  // Set when the last grant went to video; a contested grant goes the other way.
  logic rr_last_vid;
  assign grant_vid = bus.vreq && !(cpu_req && rr_last_vid);
`else
  assign grant_vid = bus.vreq;
`endif

  // Single FSM with registered SRAM strobes. The grant edge loads the address
  // (and write data), the last-count edge releases the strobes and returns to
  // IDLE, which guarantees the turnaround clock before the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      dq_oe_q   <= 1'b0;
      addr_q    <= '0;
      dq_out_q  <= 8'h00;
      cpu_din_q <= CPU_DIN_RST;
      vdata_q   <= 8'h00;
      vack_q    <= 1'b0;
`ifdef ARB_ROUNDROBIN_EN
      rr_last_vid <= 1'b0;
`endif
    end else begin
      vack_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (grant_vid) begin
            state  <= VID;
            addr_q <= bus.vaddr;
            oe_n_q <= 1'b0;
`ifdef ARB_ROUNDROBIN_EN
            rr_last_vid <= 1'b1;
`endif
          end else if (cpu_req && !bus.rd_n) begin
            state  <= CPU_RD;
            addr_q <= ADDR_W'(bus.A);
            oe_n_q <= 1'b0;
`ifdef ARB_ROUNDROBIN_EN
            rr_last_vid <= 1'b0;
`endif
          end else if (cpu_req && !bus.wr_n) begin
            state    <= CPU_WR;
            addr_q   <= ADDR_W'(bus.A);
            we_n_q   <= 1'b0;
            dq_oe_q  <= 1'b1;
            dq_out_q <= bus.cpu_dout;
`ifdef ARB_ROUNDROBIN_EN
            rr_last_vid <= 1'b0;
`endif
          end
        end
        default: begin
          if (last_cnt) begin
            state   <= IDLE;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            if (state == VID) begin
              vdata_q <= bus.sram_dq_in;
              vack_q  <= 1'b1;
            end
            if (state == CPU_RD) begin
              cpu_din_q <= bus.sram_dq_in;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.sram_addr   = addr_q;
  assign bus.sram_oe_n   = oe_n_q;
  assign bus.sram_we_n   = we_n_q;
  assign bus.sram_dq_oe  = dq_oe_q;
  assign bus.sram_dq_out = dq_out_q;
  assign bus.cpu_din     = cpu_din_q;
  assign bus.vdata       = vdata_q;
  assign bus.vack        = vack_q;
  assign bus.wait_n      = cpu_wait_n;

endmodule

// File: tb/tb_z80_sram_arbiter.sv
// Self-checking bench for z80_sram_arbiter (SRAM_CYCLES = 2).
// An SRAM model answers reads from a fixed address pattern unless a location
// was written. Expected CPU and video read data are queued when a request is
// driven and compared when the DUT completes it.
module tb_z80_sram_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  z80_sram_arbiter_if #(.ADDR_W(16)) bus ();

  z80_sram_arbiter #(
    .SRAM_CYCLES (2),
    .ADDR_W      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // SRAM model: unwritten locations read back a pattern; writes land on the edge.
  bit         mem_valid [0:65535];
  logic [7:0] mem_data  [0:65535];

  function automatic logic [7:0] sramPattern(input logic [15:0] a);
    return a[7:0] + a[15:8] + 8'h1A;
  endfunction

  assign bus.sram_dq_in = mem_valid[bus.sram_addr] ? mem_data[bus.sram_addr]
                                                   : sramPattern(bus.sram_addr);

  always @(posedge clk) begin
    if (!bus.sram_we_n && bus.sram_dq_oe) begin
      mem_valid[bus.sram_addr] <= 1'b1;
      mem_data[bus.sram_addr]  <= bus.sram_dq_out;
    end
  end

  // Strobe monitor, sampled mid-cycle.
  int         oeLow, oeFalls, weLow, weFalls, weBad;
  logic       oePrev = 1'b1;
  logic       wePrev = 1'b1;
  logic [7:0] wrExp;

  always @(negedge clk) begin
    if (!bus.sram_oe_n) oeLow++;
    if (oePrev && !bus.sram_oe_n) oeFalls++;
    if (!bus.sram_we_n) begin
      weLow++;
      if (!bus.sram_dq_oe || bus.sram_dq_out !== wrExp) weBad++;
    end
    if (wePrev && !bus.sram_we_n) weFalls++;
    oePrev = bus.sram_oe_n;
    wePrev = bus.sram_we_n;
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] cpuExp [$];
  logic [7:0] vidExp [$];
  int         vidLeft = 0;
  int         vackCount = 0;
  logic       curRead;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic clearCounters();
    oeLow = 0; oeFalls = 0; weLow = 0; weFalls = 0; weBad = 0; vackCount = 0;
  endtask

  task automatic startVideo(input logic [15:0] addr, input int more);
    vidLeft   = more;
    bus.vaddr = addr;
    bus.vreq  = 1'b1;
    vidExp.push_back(sramPattern(addr));
  endtask

  // Called mid-cycle: on vack, check data and either move to the next
  // address or drop vreq in the same cycle.
  task automatic serviceVideo();
    logic [15:0] next;
    if (bus.vack) begin
      vackCount++;
      if (vidExp.size() > 0) checkOutput("vdata", bus.vdata, vidExp.pop_front());
      else checkOutput("vack_unexpected", 1, 0);
      if (vidLeft > 0) begin
        vidLeft--;
        next = bus.vaddr + 16'h0010;
        bus.vaddr = next;
        vidExp.push_back(sramPattern(next));
      end else begin
        bus.vreq = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic isRead, input logic [15:0] addr,
                               input logic [7:0] data);
    curRead      = isRead;
    bus.A        = addr;
    bus.cpu_dout = data;
    bus.mreq_n   = 1'b0;
    if (isRead) begin
      bus.rd_n = 1'b0;
      cpuExp.push_back(data);
    end else begin
      bus.wr_n = 1'b0;
      wrExp    = data;
    end
  endtask

  // Counts mid-cycle samples with wait_n low until it rises.
  task automatic waitCpuDone(input string tag, output int waitClocks);
    bit done = 0;
    waitClocks = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      serviceVideo();
      if (bus.wait_n) begin
        done = 1;
        break;
      end
      waitClocks++;
    end
    if (!done) checkOutput({tag, "_timeout"}, 0, 1);
    else if (curRead && cpuExp.size() > 0)
      checkOutput({tag, "_cpu_din"}, bus.cpu_din, cpuExp.pop_front());
  endtask

  task automatic endCpu();
    bus.mreq_n = 1'b1;
    bus.rd_n   = 1'b1;
    bus.wr_n   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drainVideo();
    for (int i = 0; i < 200 && bus.vreq; i++) begin
      @(negedge clk);
      serviceVideo();
    end
    if (bus.vreq) checkOutput("video_drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w;
    rst          = 1'b1;
    bus.mreq_n   = 1'b1;
    bus.rd_n     = 1'b1;
    bus.wr_n     = 1'b1;
    bus.A        = 16'h0000;
    bus.cpu_dout = 8'h00;
    bus.vreq     = 1'b0;
    bus.vaddr    = 16'h0000;
    wrExp        = 8'h00;
    curRead      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_oe_n",   bus.sram_oe_n,   1);
    checkOutput("rst_we_n",   bus.sram_we_n,   1);
    checkOutput("rst_dq_oe",  bus.sram_dq_oe,  0);
    checkOutput("rst_addr",   bus.sram_addr,   0);
    checkOutput("rst_dq_out", bus.sram_dq_out, 0);
    checkOutput("rst_cpu_din", bus.cpu_din,    8'hFF);
    checkOutput("rst_vdata",  bus.vdata,       0);
    checkOutput("rst_vack",   bus.vack,        0);
    checkOutput("rst_wait_n", bus.wait_n,      1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Uncontended read.
    clearCounters();
    applyStimulus(1'b1, 16'h4000, 8'h5A);
    waitCpuDone("rd1", w);
    checkOutput("rd1_wait",     w,       3);
    checkOutput("rd1_oe_low",   oeLow,   2);
    checkOutput("rd1_oe_falls", oeFalls, 1);
    endCpu();

    // Write then read back.
    clearCounters();
    applyStimulus(1'b0, 16'h8001, 8'hC3);
    waitCpuDone("wr1", w);
    checkOutput("wr1_wait",     w,       3);
    checkOutput("wr1_we_low",   weLow,   2);
    checkOutput("wr1_we_falls", weFalls, 1);
    checkOutput("wr1_dq_bad",   weBad,   0);
    endCpu();
    applyStimulus(1'b1, 16'h8001, 8'hC3);
    waitCpuDone("rb1", w);
    checkOutput("rb1_wait", w, 3);
    endCpu();

    // Video and CPU request in the same cycle: video first.
    clearCounters();
    startVideo(16'h1800, 0);
    applyStimulus(1'b1, 16'h6000, 8'h7A);
    waitCpuDone("cont", w);
    checkOutput("cont_wait", w,         6);
    checkOutput("cont_vack", vackCount, 1);
    endCpu();
    drainVideo();

    // Video held for ten accesses with a CPU read pending.
    clearCounters();
    startVideo(16'h2000, 9);
    applyStimulus(1'b1, 16'h3000, sramPattern(16'h3000));
    waitCpuDone("starve", w);
`ifdef ARB_ROUNDROBIN_EN
    checkOutput("rr_wait_le6", (w <= 6), 1);
`else
    checkOutput("starve_wait", w, 33);
`endif
    endCpu();
    drainVideo();
    checkOutput("starve_vacks", vackCount, 10);

    // Reset in the middle of a write.
    clearCounters();
    applyStimulus(1'b0, 16'h9000, 8'h11);
    @(posedge clk);
    @(negedge clk);
    checkOutput("wrrst_started", bus.sram_we_n, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("wrrst_we_n",   bus.sram_we_n,  1);
    checkOutput("wrrst_dq_oe",  bus.sram_dq_oe, 0);
    checkOutput("wrrst_oe_n",   bus.sram_oe_n,  1);
    checkOutput("wrrst_vack",   bus.vack,       0);
    checkOutput("wrrst_wait_n", bus.wait_n,     0);
    rst = 1'b0;
    weFalls = 0;
    waitCpuDone("wrrst", w);
    checkOutput("wrrst_reserve", weFalls, 1);
    endCpu();
    applyStimulus(1'b1, 16'h9000, 8'h11);
    waitCpuDone("rb2", w);
    endCpu();

    // mreq_n held low after completion: one access only.
    clearCounters();
    applyStimulus(1'b1, 16'h4000, 8'h5A);
    waitCpuDone("hold", w);
    w = 0;
    repeat (8) begin
      @(negedge clk);
      if (!bus.wait_n) w++;
    end
    checkOutput("hold_wait_after", w,       0);
    checkOutput("hold_oe_falls",   oeFalls, 1);
    endCpu();
    applyStimulus(1'b1, 16'h5000, 8'h6A);
    waitCpuDone("hold2", w);
    checkOutput("hold2_wait",     w,       3);
    checkOutput("hold2_oe_falls", oeFalls, 2);
    endCpu();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
